// File: rtl/trigger_snapshot_buf.sv
// Double-buffered frame snapshot: copies a trigger-aligned window of the capture
// array into a shadow buffer LANES words per cycle, then publishes it atomically.
module trigger_snapshot_buf #(
   parameter  int DATA_W = 12,
   parameter  int DEPTH  = 256,
   parameter  int LANES  = 1,
   localparam int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read,
   input  logic [IDX_W-1:0]  start_idx,
   input  logic [DATA_W-1:0] data [0:DEPTH-1],
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic [7:0]        frame_id,
   output logic [DATA_W-1:0] data_output [0:DEPTH-1]
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ARM    = 2'd1;
   localparam logic [1:0] S_COPY   = 2'd2;
   localparam logic [1:0] S_COMMIT = 2'd3;

   logic [1:0]        r_state;
   logic [IDX_W:0]    r_idx;
   logic [IDX_W-1:0]  r_offs;
   logic [DATA_W-1:0] r_shadow [0:DEPTH-1];

   logic [IDX_W-1:0]  w_dst [LANES];
   logic [IDX_W-1:0]  w_src [LANES];
   logic              w_last;

   // IDX_W-bit sums wrap modulo DEPTH, which gives the circular read window for free.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign w_dst[gi] = r_idx[IDX_W-1:0] + IDX_W'(gi);
         assign w_src[gi] = r_offs + w_dst[gi];
      end
   endgenerate

   assign w_last = (r_idx == (IDX_W+1)'(DEPTH - LANES));
   assign ready  = (r_state == S_IDLE);
   assign busy   = ~ready;

   always_ff @(posedge clk) begin
      if (r_state == S_COPY) begin
         for (int l = 0; l < LANES; l++) begin
            r_shadow[w_dst[l]] <= data[w_src[l]];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_offs   <= '0;
         done     <= 1'b0;
         frame_id <= 8'd0;
         for (int i = 0; i < DEPTH; i++) begin
            data_output[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (read) begin
                  r_offs  <= start_idx;
                  r_idx   <= '0;
                  r_state <= S_ARM;
               end
            end
            S_ARM: begin
               r_state <= S_COPY;
            end
            S_COPY: begin
               r_idx <= r_idx + (IDX_W+1)'(LANES);
               if (w_last) begin
                  r_state <= S_COMMIT;
               end
            end
            S_COMMIT: begin
               data_output <= r_shadow;
               done        <= 1'b1;
               frame_id    <= frame_id + 8'd1;
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trigger_snapshot_buf.sv
// Self-checking bench for trigger_snapshot_buf: LANES=1 and LANES=4 instances
// checked against a modular-index frame model.
module tb_trigger_snapshot_buf;

   localparam int DW    = 12;
   localparam int DEPTH = 256;

   logic          clk;
   logic          rst;
   logic          read;
   logic          read4;
   logic [7:0]    start_idx;
   logic [DW-1:0] data [0:DEPTH-1];

   logic          ready1, busy1, done1;
   logic [7:0]    fid1;
   logic [DW-1:0] out1 [0:DEPTH-1];
   logic          ready4, busy4, done4;
   logic [7:0]    fid4;
   logic [DW-1:0] out4 [0:DEPTH-1];

   int checks = 0;
   int errors = 0;
   int exp_f [0:DEPTH-1];

   typedef struct {
      int start;
      int word;
      int exp_val;
   } vec_t;
   vec_t vecs [8];

   trigger_snapshot_buf #(.DATA_W(DW), .DEPTH(DEPTH), .LANES(1)) dut1 (
      .clk(clk), .rst(rst), .read(read), .start_idx(start_idx), .data(data),
      .ready(ready1), .busy(busy1), .done(done1), .frame_id(fid1), .data_output(out1)
   );

   trigger_snapshot_buf #(.DATA_W(DW), .DEPTH(DEPTH), .LANES(4)) dut4 (
      .clk(clk), .rst(rst), .read(read4), .start_idx(start_idx), .data(data),
      .ready(ready4), .busy(busy4), .done(done4), .frame_id(fid4), .data_output(out4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference: output word i is the source word at (start + i) mod DEPTH.
   task automatic model_frame(input int offs);
      for (int i = 0; i < DEPTH; i++) exp_f[i] = int'(data[(offs + i) % DEPTH]);
   endtask

   task automatic set_ramp(input int base);
      for (int i = 0; i < DEPTH; i++) data[i] = DW'(i + base);
   endtask

   task automatic set_random();
      for (int i = 0; i < DEPTH; i++) data[i] = DW'($urandom);
   endtask

   task automatic cmp_frame(input string name, input bit sel);
      int bad;
      int fi;
      int got;
      bad = 0;
      fi  = -1;
      for (int i = 0; i < DEPTH; i++) begin
         got = sel ? int'(out4[i]) : int'(out1[i]);
         if (got !== exp_f[i]) begin
            bad++;
            if (fi < 0) fi = i;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         got = sel ? int'(out4[fi]) : int'(out1[fi]);
         $display("FAIL %s word %0d got %0d expected %0d (%0d bad words)", name, fi, got, exp_f[fi], bad);
      end
   endtask

   task automatic do_frame1(input int start, output int lat);
      start_idx = 8'(start);
      read = 1'b1;
      step(1);
      read = 1'b0;
      lat = 0;
      while (!done1 && lat < DEPTH + 20) begin
         step(1);
         lat++;
      end
   endtask

   task automatic async_reset();
      #3;
      rst = 1'b1;
      #1;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int lat;
      int cnt;
      int dones;
      int fid0;
      int st;
      bit held;

      vecs[0] = '{250, 0, 250};
      vecs[1] = '{250, 5, 255};
      vecs[2] = '{250, 6, 0};
      vecs[3] = '{250, 255, 249};
      vecs[4] = '{0, 0, 0};
      vecs[5] = '{0, 255, 255};
      vecs[6] = '{1, 255, 0};
      vecs[7] = '{128, 127, 255};

      rst = 1'b1; read = 1'b0; read4 = 1'b0; start_idx = 8'd0;
      set_ramp(0);
      step(2);
      chk("rst_ready", int'(ready1), 1);
      chk("rst_busy", int'(busy1), 0);
      chk("rst_done", int'(done1), 0);
      chk("rst_fid", int'(fid1), 0);
      for (int i = 0; i < DEPTH; i++) exp_f[i] = 0;
      cmp_frame("rst_outputs", 1'b0);
      rst = 1'b0;
      step(1);

      // Basic frame, walking the latency edge by edge
      start_idx = 8'd0;
      read = 1'b1;
      step(1);
      read = 1'b0;
      chk("basic_ready_fall", int'(ready1), 0);
      chk("basic_busy", int'(busy1), 1);
      held = 1'b1;
      for (int n = 1; n <= DEPTH + 1; n++) begin
         step(1);
         if (done1 || out1[1] !== 0 || out1[255] !== 0) held = 1'b0;
      end
      chk("basic_hold_zero", int'(held), 1);
      step(1);
      chk("basic_done", int'(done1), 1);
      chk("basic_fid", int'(fid1), 1);
      chk("basic_ready_back", int'(ready1), 1);
      model_frame(0);
      cmp_frame("basic_frame", 1'b0);
      $display("frame basic id %0d", fid1);
      step(1);
      chk("basic_done_one_cycle", int'(done1), 0);

      // Asynchronous reset between edges
      async_reset();
      chk("areset_ready", int'(ready1), 1);
      chk("areset_done", int'(done1), 0);
      chk("areset_fid", int'(fid1), 0);
      for (int i = 0; i < DEPTH; i++) exp_f[i] = 0;
      cmp_frame("areset_outputs", 1'b0);
      release_reset();

      // Atomicity and dropped mid-copy request
      set_ramp(0);
      do_frame1(0, lat);
      chk("atom_pre_fid", int'(fid1), 1);
      start_idx = 8'd0;
      read = 1'b1;
      step(1);
      read = 1'b0;
      step(DEPTH/2 - 27);
      set_ramp(256);
      read = 1'b1;
      step(1);
      read = 1'b0;
      lat = 102;
      held = 1'b1;
      while (!done1 && lat < DEPTH + 20) begin
         if (out1[150] !== 150 || out1[255] !== 255) held = 1'b0;
         step(1);
         lat++;
      end
      chk("atom_hold_old", int'(held), 1);
      chk("atom_latency", lat, DEPTH + 2);
      chk("atom_fid", int'(fid1), 2);
      for (int k = 0; k < DEPTH; k++) exp_f[k] = (k < 100) ? k : k + 256;
      cmp_frame("atom_frame", 1'b0);
      $display("frame atomic id %0d", fid1);
      dones = 0;
      repeat (270) begin
         step(1);
         if (done1) dones++;
      end
      chk("atom_no_extra_done", dones, 0);
      chk("atom_fid_stable", int'(fid1), 2);

      // Table-driven offset vectors
      set_ramp(0);
      st = -1;
      for (int v = 0; v < 8; v++) begin
         if (vecs[v].start != st) begin
            st = vecs[v].start;
            do_frame1(st, lat);
            chk("vec_latency", lat, DEPTH + 2);
            $display("frame table start %0d id %0d", st, fid1);
         end
         chk($sformatf("vec%0d_word%0d", v, vecs[v].word), int'(out1[vecs[v].word]), vecs[v].exp_val);
      end

      // Random data and offsets against the model
      for (int r = 0; r < 4; r++) begin
         set_random();
         st = $urandom_range(0, DEPTH - 1);
         model_frame(st);
         do_frame1(st, lat);
         chk("rand_latency", lat, DEPTH + 2);
         cmp_frame($sformatf("rand_frame%0d", r), 1'b0);
         $display("frame random start %0d id %0d", st, fid1);
      end

      // Back-to-back frames with read held high
      set_random();
      st = $urandom_range(0, DEPTH - 1);
      model_frame(st);
      fid0 = int'(fid1);
      start_idx = 8'(st);
      read = 1'b1;
      step(1);
      for (int f = 1; f <= 3; f++) begin
         cnt = 0;
         do begin
            step(1);
            cnt++;
         end while (!done1 && cnt < 400);
         if (f == 3) read = 1'b0;
         chk($sformatf("b2b_period%0d", f), cnt, (f == 1) ? DEPTH + 2 : DEPTH + 3);
         chk("b2b_fid", int'(fid1), (fid0 + f) % 256);
         cmp_frame("b2b_frame", 1'b0);
         $display("frame b2b id %0d period %0d", fid1, cnt);
      end
      step(300);

      // Reset in the middle of COPY
      set_ramp(0);
      start_idx = 8'd0;
      read = 1'b1;
      step(1);
      read = 1'b0;
      step(101);
      async_reset();
      chk("mid_reset_ready", int'(ready1), 1);
      chk("mid_reset_fid", int'(fid1), 0);
      for (int i = 0; i < DEPTH; i++) exp_f[i] = 0;
      cmp_frame("mid_reset_outputs", 1'b0);
      release_reset();
      dones = 0;
      repeat (300) begin
         step(1);
         if (done1) dones++;
      end
      chk("mid_reset_no_done", dones, 0);
      model_frame(0);
      do_frame1(0, lat);
      chk("post_reset_latency", lat, DEPTH + 2);
      chk("post_reset_fid", int'(fid1), 1);
      cmp_frame("post_reset_frame", 1'b0);

      // LANES=4: 256 back-to-back frames, frame_id wrap
      async_reset();
      release_reset();
      set_random();
      st = $urandom_range(0, DEPTH - 1);
      model_frame(st);
      start_idx = 8'(st);
      read4 = 1'b1;
      step(1);
      for (int f = 1; f <= 256; f++) begin
         cnt = 0;
         do begin
            step(1);
            cnt++;
         end while (!done4 && cnt < 200);
         if (f == 256) read4 = 1'b0;
         chk($sformatf("l4_period%0d", f), cnt, (f == 1) ? DEPTH/4 + 2 : DEPTH/4 + 3);
         chk($sformatf("l4_fid%0d", f), int'(fid4), f % 256);
         cmp_frame("l4_frame", 1'b1);
         $display("frame lanes4 id %0d period %0d", fid4, cnt);
      end
      step(80);
      chk("l4_idle_after", int'(ready4), 1);
      chk("l4_fid_wrapped", int'(fid4), 0);

      do_frame1(st, lat);
      held = 1'b1;
      for (int i = 0; i < DEPTH; i++) if (out1[i] !== out4[i]) held = 1'b0;
      chk("l1_vs_l4_contents", int'(held), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
